// File: rtl/octal_sample_buffer_pkg.sv
// Shared definitions for the octal sample buffer.
// Holds the ADC sample width, the channel count and the default snapshot
// depth. It also holds the readout word layout and the controller state encoding.
package octal_sample_buffer_pkg;

    localparam int unsigned DATA_W         = 14;
    localparam int unsigned NCH            = 8;
    localparam int unsigned DEPTH_LOG2_DEF = 12;
    localparam int unsigned DIN_W          = NCH * DATA_W;
    localparam int unsigned CH_W           = 3;
    localparam int unsigned RD_W           = 16;
    localparam int unsigned PAD_W          = RD_W - DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Zero-extend one ADC sample into a host readout word.
    function automatic logic [RD_W-1:0] pad_sample(input logic [DATA_W-1:0] s);
        return {{PAD_W{1'b0}}, s};
    endfunction

endpackage

// File: rtl/octal_sample_buffer_if.sv
// Capture/readout bus of the octal sample buffer.
//   load, din      : capture-side write qualifier and packed channel words
//   arm            : start a new snapshot
//   rd_en          : host read strobe
//   rd_data/rd_ch/rd_valid/rd_last : readout word, its channel, valid, final flag
//   busy, done, wr_count           : snapshot status
// The master modport drives the inputs of the buffer. The slave modport is the buffer itself.
interface octal_sample_buffer_if
    import octal_sample_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
);

    logic                  load;
    logic [DIN_W-1:0]      din;
    logic                  arm;
    logic                  rd_en;
    logic [RD_W-1:0]       rd_data;
    logic [CH_W-1:0]       rd_ch;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  busy;
    logic                  done;
    logic [DEPTH_LOG2:0]   wr_count;

    modport master (
        output load, din, arm, rd_en,
        input  rd_data, rd_ch, rd_valid, rd_last, busy, done, wr_count
    );

    modport slave (
        input  load, din, arm, rd_en,
        output rd_data, rd_ch, rd_valid, rd_last, busy, done, wr_count
    );

endinterface

// File: rtl/octal_sample_buffer_sample_ram.sv
// Single-channel sample store. This is a simple dual-port RAM of 2^ADDR_W x WIDTH.
//   clk          : frame clock
//   we/waddr/wdata : write port
//   re/raddr     : read port request
//   rdata        : registered read data, valid the cycle after re
// The RAM has no reset. Its contents are undefined until written.
module octal_sample_buffer_sample_ram
    import octal_sample_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = DEPTH_LOG2_DEF,
    parameter int unsigned WIDTH  = DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // Block-RAM style: write-first is irrelevant because the two ports never collide.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/octal_sample_buffer.sv
// Octal sample buffer: records a fixed-depth snapshot of eight ADC channels
// and replays it to the host one word per read strobe, ordered A..H within
// each sample index.
//   clk, rst : frame clock, synchronous active-high reset
//   bus      : capture inputs (load, din, arm), host read (rd_en, rd_*),
//              status (busy, done, wr_count)
// Read latency is two cycles: a read-address register, then the registered RAM output.
module octal_sample_buffer
    import octal_sample_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    octal_sample_buffer_if.slave  bus
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = AW + CH_W;

    state_t state_q, state_d;

    logic [AW-1:0]   wr_addr_q;
    logic [CW-1:0]   wr_count_q;
    logic [AW-1:0]   rd_addr_q;
    logic [CH_W-1:0] rd_chan_q;

    logic            wr_en_c;
    logic            rd_acc_c;
    logic            clr_c;
    logic            wr_last_c;
    logic            rd_last_c;

    // Read pipeline: stage 1 is the RAM address register, stage 2 aligns with RAM output.
    logic            s1_valid_q, s2_valid_q;
    logic [CH_W-1:0] s1_ch_q,    s2_ch_q;
    logic            s1_last_q,  s2_last_q;
    logic [AW-1:0]   raddr_q;

    logic            busy_q, done_q;

    logic [DATA_W-1:0] ram_q [NCH];

    assign wr_last_c = (wr_addr_q == AW'(DEPTH - 1));
    assign rd_last_c = (rd_addr_q == AW'(DEPTH - 1)) && (rd_chan_q == CH_W'(NCH - 1));

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes. arm in DONE takes priority over rd_en.
    always_comb begin
        state_d  = state_q;
        wr_en_c  = 1'b0;
        rd_acc_c = 1'b0;
        clr_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_d = ST_ARMED;
                    clr_c   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (bus.load) begin
                    wr_en_c = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.load) begin
                    wr_en_c = 1'b1;
                    if (wr_last_c) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.arm) begin
                    state_d = ST_ARMED;
                    clr_c   = 1'b1;
                end else if (bus.rd_en) begin
                    rd_acc_c = 1'b1;
                    if (rd_last_c) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write pointer and saturating sample count. The address is 0 on entry to ARMED.
    always_ff @(posedge clk) begin
        if (rst || clr_c) begin
            wr_addr_q  <= '0;
            wr_count_q <= '0;
        end else if (wr_en_c) begin
            wr_addr_q <= wr_addr_q + AW'(1);
            if (wr_count_q != CW'(DEPTH)) begin
                wr_count_q <= wr_count_q + CW'(1);
            end
        end
    end

    // Read pointer {addr, chan}. It counts as one word index and wraps to 0 after the last word.
    always_ff @(posedge clk) begin
        if (rst || clr_c) begin
            rd_addr_q <= '0;
            rd_chan_q <= '0;
        end else if (rd_acc_c) begin
            {rd_addr_q, rd_chan_q} <= {rd_addr_q, rd_chan_q} + PW'(1);
        end
    end

    // Read pipeline. arm does not flush it, so accepted words still emerge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_last_q  <= 1'b0;
            raddr_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_ch_q    <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= rd_acc_c;
            if (rd_acc_c) begin
                raddr_q   <= rd_addr_q;
                s1_ch_q   <= rd_chan_q;
                s1_last_q <= rd_last_c;
            end
            s2_valid_q <= s1_valid_q;
            s2_ch_q    <= s1_ch_q;
            s2_last_q  <= s1_last_q;
        end
    end

    // Status flags are registered from the next state so that they track state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
            done_q <= (state_d == ST_DONE);
        end
    end

    // One RAM per channel. All channels share the write and read addresses.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        octal_sample_buffer_sample_ram #(
            .ADDR_W (AW),
            .WIDTH  (DATA_W)
        ) u_ram (
            .clk   (clk),
            .we    (wr_en_c),
            .waddr (wr_addr_q),
            .wdata (bus.din[g*DATA_W +: DATA_W]),
            .re    (s1_valid_q),
            .raddr (raddr_q),
            .rdata (ram_q[g])
        );
    end

    // Select the word by its pipelined channel index. The mux is gated to 0 so
    // that uninitialised RAM never shows on the bus.
    assign bus.rd_data  = s2_valid_q ? pad_sample(ram_q[s2_ch_q]) : '0;
    assign bus.rd_ch    = s2_ch_q;
    assign bus.rd_valid = s2_valid_q;
    assign bus.rd_last  = s2_valid_q & s2_last_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wr_count = wr_count_q;

endmodule
